mux_sel_arbiter: RTL and testbench
==================================

# mux_sel_arbiter

Round-robin arbiter that shares one 4:1 result mux between four requesters (ALU, memory load, PC+4 link, immediate/LUI paths). It owns the mux `sel` code and registers it, so the shared output carries one source per cycle. It raises a valid qualifier and a one-hot grant back to each requester. It sits between the datapath sources and the register-file write port.

## Interface
- `DATA_W`, default 32: width of each source and of the muxed output.
- `HOLD_MAX`, default 8: maximum consecutive grant cycles for one owner while others wait. Only used with `MUX_ARB_TIMEOUT_EN`. Must be at least 1.

- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `req`: input, 4 bits. Request lines; bit i is requester i. Level-sensitive; held high for as long as the requester wants the mux.
- `d0`, `d1`, `d2`, `d3`: input, `DATA_W` bits each. Source data.
- `gnt`: output, 4 bits. One-hot registered grant, or all zeros.
- `sel`: output, 2 bits. Registered mux select, equal to the index of the granted requester.
- `y`: output, `DATA_W` bits. Muxed data; 0 when `valid` is low.
- `valid`: output, 1 bit. High when `y` carries owner data: `gnt != 0` and `req[sel]` is high.
- `busy`: output, 1 bit. High when `gnt != 0`.

## Operation
- Two states:
  - IDLE: `gnt` is 0.
  - OWN: exactly one `gnt` bit is set.
- Round-robin pointer `last[1:0]` holds the most recent owner. Search order is `last+1`, `last+2`, `last+3`, `last`, all modulo 4.
- IDLE:
  - If any `req` bit is high, grant the first requester in search order and go to OWN.
  - Otherwise stay in IDLE.
- OWN with `req[sel]` high: hold the grant; `gnt` and `sel` do not change. Forced release exists only with the timeout feature.
- OWN with `req[sel]` low (owner released):
  - If other requests are pending, grant the next in search order and stay in OWN. The hand-off has no idle bubble.
  - If none are pending, go to IDLE with `gnt` = 0.
- `last` updates to the new owner index on every grant edge.
- A requester that drops and re-raises `req` in consecutive cycles is treated as a new request. It is queued behind the others by the round-robin order.
- `y` is combinational from the registered `sel`: d0, d1, d2 or d3, gated to 0 when `valid` is low.
- A requester whose `req` rises while another owns the mux waits. It must keep `req` high until it sees its own `gnt` bit.
- Reset values:
  - `gnt` = 0, `sel` = 0, `valid` = 0, `busy` = 0, `y` = 0.
  - State = IDLE.
  - `last` = 3, so requester 0 wins first.
  - Hold counter = 0.
- Reset asserted mid-grant: on the same edge, return to the reset values. Pending requests are re-arbitrated from `last` = 3 on the first edge after `reset` falls.

## Timing
- Request to grant latency is 1 cycle. `req` high at edge t-1 and sampled at edge t gives `gnt`, `sel` and `valid` after edge t.
- Release to hand-off latency is 1 cycle. The owner drops `req` in cycle t; the new `gnt` appears after edge t+1. In cycle t, `busy` = 1 and `valid` = 0.
- Simultaneous requests are resolved purely by the search order from `last`.
- An owner release and a new request arriving in the same cycle: the new request competes in that cycle's arbitration.
- `gnt` and `sel` never change except on a clock edge. `gnt` is never multi-hot.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - A hold counter increments each cycle in OWN and clears on every grant change.
  - When the counter reaches `HOLD_MAX - 1` with the owner still requesting and at least one other `req` high, the next edge grants the next requester in search order.
  - The evicted owner keeps its `req` high and re-queues.
  - With no competitor present, the counter saturates and the grant is held.
- `MUX_ARB_TIMEOUT_EN` undefined: no counter; an owner holds the mux indefinitely while `req[sel]` is high.

## Test plan
- Reset, then `req` = 4'b0000 for 5 cycles -> `gnt` = 0, `valid` = 0, `y` = 0 throughout.
- Out of reset, `req` = 4'b1111 and held; each owner drops `req` for one cycle after 2 cycles of ownership -> grants go 0,1,2,3,0 with no idle cycle between owners, `sel` tracks each grant, and `y` equals the matching d0..d3.
- `req` = 4'b0100 alone -> `gnt` = 4'b0100 one cycle later, `sel` = 2, `y` = d2. Drop `req` -> `gnt` = 0 one cycle later.
- Requester 1 owns the mux; `reset` is pulsed for 1 cycle while `req` = 4'b0011 -> all outputs 0 after the reset edge, then `gnt` = 4'b0001 on the first edge after reset falls.
- With `MUX_ARB_TIMEOUT_EN` and `HOLD_MAX` = 4, `req` = 4'b1001 held -> requester 0 owns for 4 cycles, then requester 3 owns for 4 cycles, alternating.
- Without the macro, the same stimulus -> requester 0 holds indefinitely.

Source files
------------

// File: rtl/mux_sel_arbiter_if.sv
// Bus bundle for mux_sel_arbiter: request/data lines from the datapath
// sources and the grant/select/muxed-result lines back out.
interface mux_sel_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        req;
  logic [DATA_W-1:0] d0, d1, d2, d3;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic [DATA_W-1:0] y;
  logic              valid;
  logic              busy;

  // Requester side: drives requests and source data, sees grant and result.
  modport master (
    output req, d0, d1, d2, d3,
    input  gnt, sel, y, valid, busy
  );

  // Arbiter side.
  modport slave (
    input  req, d0, d1, d2, d3,
    output gnt, sel, y, valid, busy
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 result mux.
// Four requesters hold req high while they want the mux; the winner gets a
// registered one-hot gnt and sel, and y carries its data while it still
// requests. Hand-off on release has no idle bubble.
// Optional feature: define MUX_ARB_TIMEOUT_EN to force an owner off the mux
// after HOLD_MAX consecutive cycles while another requester waits.
module mux_sel_arbiter #(
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 8
) (
  input  logic           clk,
  input  logic           reset,
  mux_sel_arbiter_if.slave bus
);

  if (HOLD_MAX < 1) begin : g_hold_chk
    $error("mux_sel_arbiter: HOLD_MAX must be at least 1");
  end

  typedef enum logic {IDLE, OWN} state_e;

  state_e     state_q, state_d;
  logic [1:0] sel_q,   sel_d;
  logic [1:0] last_q,  last_d;
  logic [3:0] gnt_q,   gnt_d;

  logic       do_grant;
  logic [3:0] grant_mask;
  logic [3:0] others;
  logic [2:0] pick;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(HOLD_MAX - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // First set bit of m searching base+1, base+2, base+3, base; {found, idx}.
  // Walk the order backwards so the earliest candidate is written last.
  function automatic logic [2:0] rr_pick(input logic [3:0] m, input logic [1:0] base);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (m[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // Next-state: pick a new owner on idle request, release, or eviction.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    do_grant   = 1'b0;
    grant_mask = '0;
    others     = bus.req & ~gnt_q;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          do_grant   = 1'b1;
          grant_mask = bus.req;
        end
      end
      OWN: begin
        if (bus.req[sel_q]) begin
`ifdef MUX_ARB_TIMEOUT_EN
          if (cnt_q == CNT_TOP && |others) begin
            do_grant   = 1'b1;
            grant_mask = others;
          end
`endif
        end else if (|others) begin
          do_grant   = 1'b1;
          grant_mask = others;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    pick = rr_pick(grant_mask, last_q);
    if (do_grant) begin
      state_d = OWN;
      sel_d   = pick[1:0];
      last_d  = pick[1:0];
      gnt_d   = 4'b0001 << pick[1:0];
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Hold counter: clears on any grant change or idle, saturates at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (do_grant || state_d == IDLE) cnt_d = '0;
    else if (cnt_q != CNT_TOP)       cnt_d = cnt_q + 1'b1;
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  // Arbiter state register; last=3 so requester 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  logic              valid_w;
  logic [DATA_W-1:0] y_w;

  // Result mux off the registered select, zeroed unless the owner still requests.
  always_comb begin
    valid_w = (|gnt_q) && bus.req[sel_q];
    y_w     = '0;
    if (valid_w) begin
      case (sel_q)
        2'd0:    y_w = bus.d0;
        2'd1:    y_w = bus.d1;
        2'd2:    y_w = bus.d2;
        default: y_w = bus.d3;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_w;
  assign bus.busy  = |gnt_q;
  assign bus.y     = y_w;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed scenarios with literal expectations
// plus a long randomized run checked every cycle against an owner/last model.
module tb_mux_sel_arbiter;
  localparam int DW = 32;
  localparam int HM = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  mux_sel_arbiter_if #(.DATA_W(DW)) bus ();

  mux_sel_arbiter #(.DATA_W(DW), .HOLD_MAX(HM)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: current owner (-1 = none), most recent owner, hold count.
  int m_owner = -1;
  int m_last  = 3;
  int m_cnt   = 0;
  int m_nxt;
  int m_alt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_next(input logic [3:0] r, input int from, input int skip);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (from + k) % 4;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] src(input int i);
    case (i)
      0:       return bus.d0;
      1:       return bus.d1;
      2:       return bus.d2;
      default: return bus.d3;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1;
      m_last  = 3;
      m_cnt   = 0;
    end else begin
      m_nxt = m_owner;
      if (m_owner < 0)
        m_nxt = rr_next(bus.req, m_last, -1);
      else if (!bus.req[m_owner])
        m_nxt = rr_next(bus.req, m_last, m_owner);
      else if (TO && m_cnt >= HM - 1) begin
        m_alt = rr_next(bus.req, m_last, m_owner);
        if (m_alt >= 0) m_nxt = m_alt;
      end
      if (m_nxt != m_owner) begin
        m_cnt = 0;
        if (m_nxt >= 0) m_last = m_nxt;
      end else if (m_owner >= 0 && m_cnt < HM - 1) begin
        m_cnt++;
      end
      m_owner = m_nxt;
    end
  end

  // Compare all outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic       ev;
      logic [3:0] eg;
      eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      ev = (m_owner >= 0) && bus.req[m_owner];
      chk("model_gnt",   bus.gnt,   eg);
      chk("model_busy",  bus.busy,  m_owner >= 0);
      chk("model_valid", bus.valid, ev);
      chk("model_y",     bus.y,     ev ? src(m_owner) : '0);
      if (m_owner >= 0) chk("model_sel", bus.sel, m_owner[1:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fixed_d();
    bus.d0 = 32'hD000_0000;
    bus.d1 = 32'hD000_0001;
    bus.d2 = 32'hD000_0002;
    bus.d3 = 32'hD000_0003;
  endtask

  initial begin
    reset   = 1'b1;
    bus.req = 4'b0000;
    fixed_d();
    tick();
    tick();
    chk_en = 1'b1;
    // reset state
    chk("rst_gnt",   bus.gnt,   4'b0000);
    chk("rst_sel",   bus.sel,   2'd0);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_busy",  bus.busy,  1'b0);
    chk("rst_y",     bus.y,     32'h0);
    reset = 1'b0;

    // no requests for 5 cycles
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_gnt", bus.gnt, 4'b0000);
      chk("idle_y",   bus.y,   32'h0);
    end

    // all four requesting; each owner releases for one cycle after two
    bus.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      chk("rot_gnt",   bus.gnt,   4'b0001 << o);
      chk("rot_sel",   bus.sel,   o[1:0]);
      chk("rot_valid", bus.valid, 1'b1);
      chk("rot_y",     bus.y,     32'hD000_0000 + o);
      if (k == 4) break;
      tick();
      bus.req = 4'b1111 & ~(4'b0001 << o);
      #1;
      chk("rel_busy",  bus.busy,  1'b1);
      chk("rel_valid", bus.valid, 1'b0);
      tick();
      bus.req = 4'b1111;
    end
    bus.req = 4'b0000;
    tick();
    chk("rot_end_gnt", bus.gnt, 4'b0000);

    // single requester 2
    bus.req = 4'b0100;
    tick();
    chk("r2_gnt", bus.gnt, 4'b0100);
    chk("r2_sel", bus.sel, 2'd2);
    chk("r2_y",   bus.y,   32'hD000_0002);
    bus.req = 4'b0000;
    tick();
    chk("r2_drop_gnt", bus.gnt, 4'b0000);

    // reset while requester 1 owns
    bus.req = 4'b0010;
    tick();
    chk("r1_gnt", bus.gnt, 4'b0010);
    reset   = 1'b1;
    bus.req = 4'b0011;
    tick();
    chk("mid_rst_gnt",   bus.gnt,   4'b0000);
    chk("mid_rst_sel",   bus.sel,   2'd0);
    chk("mid_rst_valid", bus.valid, 1'b0);
    chk("mid_rst_busy",  bus.busy,  1'b0);
    chk("mid_rst_y",     bus.y,     32'h0);
    reset = 1'b0;
    tick();
    chk("post_rst_gnt", bus.gnt, 4'b0001);

    // requesters 0 and 3 both held: timeout alternates, otherwise 0 keeps it
    reset   = 1'b1;
    bus.req = 4'b0000;
    tick();
    reset   = 1'b0;
    bus.req = 4'b1001;
    for (int k = 0; k < 16; k++) begin
      int e;
      tick();
      e = (TO && ((k / HM) % 2 == 1)) ? 3 : 0;
      chk("hold_gnt", bus.gnt, 4'b0001 << e);
    end

    // randomized traffic: requests mostly persist, occasional reset
    for (int k = 0; k < 800; k++) begin
      tick();
      bus.d0 = $urandom;
      bus.d1 = $urandom;
      bus.d2 = $urandom;
      bus.d3 = $urandom;
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      reset = ($urandom_range(0, 79) == 0);
    end
    reset   = 1'b0;
    bus.req = 4'b0000;
    tick();
    tick();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors %0d", n_err);
    $fatal(1);
  end
endmodule
